// File: rtl/rvsteel_gpio_irq.sv
// Memory-mapped GPIO with per-pin synchronised inputs and edge-triggered interrupts.
// Per-pin input path lives in rvsteel_gpio_irq_pin; register map and bus handling in the top.

module rvsteel_gpio_irq_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  input  logic rise_en,
  input  logic fall_en,
  output logic sync_val,
  output logic event_hit
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_val  = sync_q[SYNC_STAGES-1];
  assign event_hit = (sync_val & ~prev_q & rise_en) | (~sync_val & prev_q & fall_en);

endmodule

module rvsteel_gpio_irq #(
  parameter int GPIO_WIDTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [5:0]            rw_address,
  input  logic                  read_request,
  output logic [31:0]           read_data,
  output logic                  read_response,
  input  logic                  write_request,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_strobe,
  output logic                  write_response,
  input  logic [GPIO_WIDTH-1:0] gpio_input,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic [GPIO_WIDTH-1:0] gpio_output,
  output logic                  irq
);

  localparam int W = GPIO_WIDTH;

  logic [W-1:0] in_sync, evt;
  logic [W-1:0] oe_q, out_q, en_q, rise_q, fall_q, pend_q;
  logic [W-1:0] oe_d, out_d, en_d, rise_d, fall_d, pend_d, pend_clr;
  logic [W-1:0] wmask, wdata;
  logic [31:0]  bmask, rdata_d;
  logic [3:0]   widx;

  assign widx = rw_address[5:2];

  for (genvar i = 0; i < W; i++) begin : g_pin
    rvsteel_gpio_irq_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
      .clock     (clock),
      .reset     (reset),
      .pin       (gpio_input[i]),
      .rise_en   (rise_q[i]),
      .fall_en   (fall_q[i]),
      .sync_val  (in_sync[i]),
      .event_hit (evt[i])
    );
  end

  assign bmask = {{8{write_strobe[3]}}, {8{write_strobe[2]}},
                  {8{write_strobe[1]}}, {8{write_strobe[0]}}};
  assign wmask = bmask[W-1:0];
  assign wdata = write_data[W-1:0] & wmask;

  // W1C/W1S registers see the strobe-masked data, so a cleared strobe is a no-op.
  always_comb begin
    oe_d     = oe_q;
    out_d    = out_q;
    en_d     = en_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    pend_clr = '0;
    if (write_request) begin
      case (widx)
        4'd1: oe_d     = (oe_q & ~wmask) | wdata;
        4'd2: out_d    = (out_q & ~wmask) | wdata;
        4'd3: out_d    = out_q & ~wdata;
        4'd4: out_d    = out_q | wdata;
        4'd5: en_d     = (en_q & ~wmask) | wdata;
        4'd6: rise_d   = (rise_q & ~wmask) | wdata;
        4'd7: fall_d   = (fall_q & ~wmask) | wdata;
        4'd8: pend_clr = wdata;
        default: ;
      endcase
    end
    // A new edge wins over a same-cycle clear.
    pend_d = (pend_q & ~pend_clr) | evt;
  end

  always_comb begin
    rdata_d = '0;
    case (widx)
      4'd0: rdata_d = 32'(in_sync);
      4'd1: rdata_d = 32'(oe_q);
      4'd2: rdata_d = 32'(out_q);
      4'd5: rdata_d = 32'(en_q);
      4'd6: rdata_d = 32'(rise_q);
      4'd7: rdata_d = 32'(fall_q);
      4'd8: rdata_d = 32'(pend_q);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oe_q           <= '0;
      out_q          <= '0;
      en_q           <= '0;
      rise_q         <= '0;
      fall_q         <= '0;
      pend_q         <= '0;
      read_data      <= '0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      irq            <= 1'b0;
    end else begin
      oe_q           <= oe_d;
      out_q          <= out_d;
      en_q           <= en_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      pend_q         <= pend_d;
      if (read_request) read_data <= rdata_d;
      read_response  <= read_request;
      write_response <= write_request;
      // Registered from next-state values so irq tracks pending/enable with no extra cycle.
      irq            <= |(pend_d & en_d);
    end
  end

  assign gpio_oe     = oe_q;
  assign gpio_output = out_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, rw_address[1:0], write_data, bmask};

endmodule

// File: doc/rvsteel_gpio_irq.md
# rvsteel_gpio_irq

Parametrised GPIO controller with per-pin edge-triggered interrupts, replacing the fixed plain-I/O GPIO of the SoC with a configurable-width, interrupt-capable peripheral. It sits on the SoC system bus as a memory-mapped device between the bus fabric and the `gpio_*` pins. It drives one level interrupt line into the CPU interrupt input.

## Interface
- `GPIO_WIDTH`, default 2: number of pins, legal range 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, legal range 2..4.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; asserting it clears all state immediately.
- `rw_address` input 6: byte address, word-aligned; bits [1:0] are ignored.
- `read_request` input 1: read strobe, one cycle per access.
- `read_data` output 32: registered read data.
- `read_response` output 1: high for one cycle, one clock after `read_request`.
- `write_request` input 1: write strobe, one cycle per access.
- `write_data` input 32: write data.
- `write_strobe` input 4: byte enables; `write_strobe[n]` gates `write_data[8n+7:8n]`.
- `write_response` output 1: high for one cycle, one clock after `write_request`.
- `gpio_input` input `GPIO_WIDTH`: asynchronous pin inputs.
- `gpio_oe` output `GPIO_WIDTH`: per-pin output enable.
- `gpio_output` output `GPIO_WIDTH`: per-pin output value.
- `irq` output 1: level interrupt, `|(pending & irq_en)`, driven from flops only.

## Operation
- Register map (word offsets); bits at or above `GPIO_WIDTH` read 0 and ignore writes:
  - 0x00 IN: read-only, synchronised pin values.
  - 0x04 OE: read/write.
  - 0x08 OUT: read/write.
  - 0x0C OUT_CLR: write-1-to-clear OUT bits; reads 0.
  - 0x10 OUT_SET: write-1-to-set OUT bits; reads 0.
  - 0x14 IRQ_EN: read/write.
  - 0x18 IRQ_RISE: read/write.
  - 0x1C IRQ_FALL: read/write.
  - 0x20 IRQ_PENDING: read; write-1-to-clear.
- Addresses 0x24..0x3C are unmapped: they read 0, ignore writes, and still respond.
- Pin input path:
  - Each pin passes through a `SYNC_STAGES`-deep flop chain, then a one-flop history register `prev`.
  - `rise[i] = sync[i] & ~prev[i]`; `fall[i] = ~sync[i] & prev[i]`.
- Interrupt pending logic:
  - `pending[i]` sets when `(rise[i] & IRQ_RISE[i]) | (fall[i] & IRQ_FALL[i])`.
  - Detection is independent of IRQ_EN; IRQ_EN masks only `irq`.
- Simultaneous events:
  - Edge detect and W1C of the same pending bit in the same cycle: set wins, bit stays 1.
  - OUT_SET and OUT_CLR target different addresses, so they can never occur in the same cycle.
- Read and write channels are independent. A read and a write in the same cycle are both served. The read returns the pre-write value.
- Byte strobes apply per byte to every writable register, including the W1C and W1S registers.
- The bus master never issues a new request on a channel while its response is pending. Behaviour under back-to-back requests every cycle is still defined: each request gets its own response one cycle later.

## Timing
- Reset value of every output is 0, and every internal register (sync chain, `prev`, all map registers) resets to 0.
- Read latency is 1 cycle: `read_data` and `read_response` are valid in the cycle after `read_request`. `read_data` holds its value until the next read.
- Write latency is 1 cycle: the register updates at the same edge that raises `write_response`. `gpio_oe` and `gpio_output` change in the cycle after `write_request`.
- Pin-to-IN latency is `SYNC_STAGES` rising edges.
- Pin-to-`pending` latency is `SYNC_STAGES`+1 rising edges; `irq` follows in the same cycle as `pending` when enabled.
- W1C of the last enabled pending bit drops `irq` in the cycle after `write_request`.
- A pin held high across reset release is reported as a rising edge `SYNC_STAGES`+1 edges after release, because the sync chain resets to 0.
- Reset asserted mid-access: the response is not issued and all registers clear asynchronously. The first access after release behaves normally.
- Pulses shorter than one clock period may be missed; this is not an error.

## Test plan
- Reset release, then read all nine offsets -> every read returns 0x00000000; `gpio_oe`, `gpio_output`, `irq`, and both responses are 0.
- `GPIO_WIDTH`=2: write OE=0xFFFFFFFF, OUT=0x3, OUT_CLR=0x1 -> `gpio_oe`=2'b11, `gpio_output`=2'b10; a read of OE returns 0x00000003.
- IRQ_EN=0x1, IRQ_RISE=0x1, drive `gpio_input[0]` 0->1 -> `irq` rises exactly 3 edges later (`SYNC_STAGES`=2) and PENDING reads 0x1. Writing PENDING=0x1 drops `irq` the next cycle.
- IRQ_FALL=0x2 with IRQ_EN=0: toggle pin 1 1->0 -> PENDING=0x2 and `irq` stays 0. Then writing IRQ_EN=0x2 raises `irq` one cycle later.
- Align a W1C of PENDING bit 0 with a new detected rise on pin 0 -> PENDING bit 0 remains 1 and `irq` stays high.
- Write OUT=0xFF with `write_strobe`=4'b0000 and read 0x3C -> OUT is unchanged, the read returns 0, and both responses arrive at 1-cycle latency.
